// File: rtl/sorter_pkg.sv
// Shared types and helpers for the sorter front end.
package sorter_pkg;

  localparam int unsigned LOADER_BEAT_ELEMS = 4;
  localparam int unsigned PAD_MAX_WIDTH     = 64;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StFull
  } loader_state_e;

  typedef struct packed {
    logic [5:0] len;
    logic [3:0] num;
    logic [5:0] total;
    logic       sign;
  } loader_cfg_t;

  // Minimum representable value: 0 unsigned, MSB-only pattern signed.
  function automatic logic [PAD_MAX_WIDTH-1:0] pad_value(input logic sign,
                                                         input int unsigned width);
    logic [PAD_MAX_WIDTH-1:0] one;
    one       = {{(PAD_MAX_WIDTH-1){1'b0}}, 1'b1};
    pad_value = '0;
    if (sign) begin
      pad_value = one << (width - 1);
    end
  endfunction

endpackage

// File: rtl/sorter_frame_loader.sv
// Collects a grouping config plus a beat stream into one padded frame for the sorter.
module sorter_frame_loader
  import sorter_pkg::*;
#(
  parameter int unsigned DATAWIDTH      = 8,
  parameter int unsigned MAX_DATALENGTH = 32,
  parameter int unsigned BEAT_ELEMS     = LOADER_BEAT_ELEMS
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [5:0]           cfg_group_len_i,
  input  logic [3:0]           cfg_group_num_i,
  input  logic                 cfg_sign_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DATAWIDTH-1:0] in_data_i [BEAT_ELEMS],
  output logic                 frame_valid_o,
  input  logic                 frame_ready_i,
  output logic [DATAWIDTH-1:0] x_o [MAX_DATALENGTH],
  output logic [5:0]           total_length_o,
  output logic [3:0]           total_group_o,
  output logic                 sign_ctrl_o,
  output logic                 err_o
);

  localparam int unsigned PtrW      = $clog2(MAX_DATALENGTH + BEAT_ELEMS + 1);
  localparam logic [9:0]  MaxLenW10 = 10'(MAX_DATALENGTH);

  loader_state_e         state_q, state_d;
  logic [PtrW-1:0]       wp_q;
  logic [5:0]            total_q;
  logic [3:0]            num_q;
  logic                  sign_q;
  logic                  err_q, err_d;

  loader_cfg_t           cfg_in;
  logic [9:0]            prod;
  logic                  cfg_legal;
  logic                  cfg_load;
  logic                  beat_acc;
  logic [DATAWIDTH-1:0]  pad;

  // Decode the offered configuration; the product is wide enough to catch overflow.
  always_comb begin
    prod         = {4'b0, cfg_group_len_i} * {6'b0, cfg_group_num_i};
    cfg_in.len   = cfg_group_len_i;
    cfg_in.num   = cfg_group_num_i;
    cfg_in.total = prod[5:0];
    cfg_in.sign  = cfg_sign_i;
    cfg_legal    = (cfg_in.len != '0) && (cfg_in.num != '0) && (prod <= MaxLenW10);
    pad          = DATAWIDTH'(pad_value(cfg_in.sign, DATAWIDTH));
  end

  // Next state, handshakes and error pulse.
  always_comb begin
    state_d     = state_q;
    cfg_ready_o = 1'b0;
    cfg_load    = 1'b0;
    beat_acc    = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        cfg_ready_o = 1'b1;
        if (cfg_valid_i) begin
          if (cfg_legal) begin
            cfg_load = 1'b1;
            state_d  = StFill;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StFill: begin
        if (in_valid_i) begin
          beat_acc = 1'b1;
          if (32'(wp_q) + BEAT_ELEMS >= 32'(total_q)) begin
            state_d = StFull;
          end
        end
      end
      StFull: begin
        // Releasing the frame frees the config port in the same cycle.
        cfg_ready_o = frame_ready_i;
        if (frame_ready_i) begin
          state_d = StIdle;
          if (cfg_valid_i) begin
            if (cfg_legal) begin
              cfg_load = 1'b1;
              state_d  = StFill;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, write pointer and frame metadata.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      wp_q    <= '0;
      total_q <= '0;
      num_q   <= '0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (cfg_load) begin
        wp_q    <= '0;
        total_q <= cfg_in.total;
        num_q   <= cfg_in.num;
        sign_q  <= cfg_in.sign;
      end else if (beat_acc) begin
        wp_q <= wp_q + PtrW'(BEAT_ELEMS);
      end
    end
  end

  // Per-slot storage: a slot takes the lane of the beat whose base pointer matches it.
  for (genvar s = 0; s < MAX_DATALENGTH; s++) begin : g_slot
    localparam int unsigned SlotIdx = s;
    localparam int unsigned Lane    = SlotIdx % BEAT_ELEMS;
    localparam int unsigned Base    = SlotIdx - Lane;

    logic [DATAWIDTH-1:0] slot_q;
    logic                 slot_we;

    assign slot_we = beat_acc && (32'(wp_q) == Base) && (SlotIdx < 32'(total_q));

    // Pad on config load, then capture data only for in-range slots.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        slot_q <= '0;
      end else if (cfg_load) begin
        slot_q <= pad;
      end else if (slot_we) begin
        slot_q <= in_data_i[Lane];
      end
    end

    assign x_o[s] = slot_q;
  end

  assign in_ready_o     = (state_q == StFill);
  assign frame_valid_o  = (state_q == StFull);
  assign total_length_o = total_q;
  assign total_group_o  = num_q;
  assign sign_ctrl_o    = sign_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_sorter_frame_loader.sv
// Directed self-checking bench for sorter_frame_loader.
module tb_sorter_frame_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [5:0] cfg_len;
  logic [3:0] cfg_num;
  logic       cfg_sign;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data [4];
  logic       frame_valid;
  logic       frame_ready;
  logic [7:0] x [32];
  logic [5:0] total_length;
  logic [3:0] total_group;
  logic       sign_ctrl;
  logic       err;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  sorter_frame_loader #(
    .DATAWIDTH     (8),
    .MAX_DATALENGTH(32),
    .BEAT_ELEMS    (4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cfg_valid_i    (cfg_valid),
    .cfg_ready_o    (cfg_ready),
    .cfg_group_len_i(cfg_len),
    .cfg_group_num_i(cfg_num),
    .cfg_sign_i     (cfg_sign),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_data_i      (in_data),
    .frame_valid_o  (frame_valid),
    .frame_ready_i  (frame_ready),
    .x_o            (x),
    .total_length_o (total_length),
    .total_group_o  (total_group),
    .sign_ctrl_o    (sign_ctrl),
    .err_o          (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock and settle just past the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [5:0] len, input logic [3:0] num, input logic sign);
    cfg_valid = 1'b1;
    cfg_len   = len;
    cfg_num   = num;
    cfg_sign  = sign;
    cyc();
    cfg_valid = 1'b0;
  endtask

  // Beat carrying base, base+1, base+2, base+3.
  task automatic send_beat(input logic [7:0] base);
    for (int j = 0; j < 4; j++) in_data[j] = base + 8'(j);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic release_frame();
    frame_ready = 1'b1;
    cyc();
    frame_ready = 1'b0;
    check("release_fv", {31'b0, frame_valid}, 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    cfg_valid   = 1'b0;
    cfg_len     = '0;
    cfg_num     = '0;
    cfg_sign    = 1'b0;
    in_valid    = 1'b0;
    frame_ready = 1'b0;
    for (int j = 0; j < 4; j++) in_data[j] = '0;
    #2;
    // Reset state
    check("rst_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_fv", {31'b0, frame_valid}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_total", {26'b0, total_length}, 32'd0);
    check("rst_group", {28'b0, total_group}, 32'd0);
    check("rst_sign", {31'b0, sign_ctrl}, 32'd0);
    check("rst_x0", {24'b0, x[0]}, 32'd0);
    check("rst_x31", {24'b0, x[31]}, 32'd0);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();

    // Single group of 20 unsigned values
    send_cfg(6'd20, 4'd1, 1'b0);
    check("sg_in_ready", {31'b0, in_ready}, 32'd1);
    check("sg_cfg_ready", {31'b0, cfg_ready}, 32'd0);
    for (int b = 0; b < 5; b++) begin
      check("sg_fv_pre", {31'b0, frame_valid}, 32'd0);
      send_beat(8'(4 * b + 1));
    end
    check("sg_fv", {31'b0, frame_valid}, 32'd1);
    check("sg_in_ready_full", {31'b0, in_ready}, 32'd0);
    check("sg_cfg_ready_full", {31'b0, cfg_ready}, 32'd0);
    for (int i = 0; i < 32; i++)
      check($sformatf("sg_x%0d", i), {24'b0, x[i]}, (i < 20) ? 32'(i + 1) : 32'd0);
    check("sg_total", {26'b0, total_length}, 32'd20);
    check("sg_group", {28'b0, total_group}, 32'd1);
    check("sg_sign", {31'b0, sign_ctrl}, 32'd0);
    release_frame();
    check("sg_idle_cfg_ready", {31'b0, cfg_ready}, 32'd1);

    // Signed, partial last beat: total 21, 6 beats, 22..24 dropped
    send_cfg(6'd7, 4'd3, 1'b1);
    for (int b = 0; b < 6; b++) send_beat(8'(4 * b + 1));
    check("sp_fv", {31'b0, frame_valid}, 32'd1);
    for (int i = 0; i < 32; i++)
      check($sformatf("sp_x%0d", i), {24'b0, x[i]}, (i < 21) ? 32'(i + 1) : 32'h80);
    check("sp_total", {26'b0, total_length}, 32'd21);
    check("sp_group", {28'b0, total_group}, 32'd3);
    check("sp_sign", {31'b0, sign_ctrl}, 32'd1);
    release_frame();

    // Illegal configurations: consumed, one-cycle err, stay idle
    send_cfg(6'd9, 4'd4, 1'b0);
    check("ill36_err", {31'b0, err}, 32'd1);
    check("ill36_in_ready", {31'b0, in_ready}, 32'd0);
    check("ill36_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    cyc();
    check("ill36_err_drop", {31'b0, err}, 32'd0);
    check("ill36_in_ready2", {31'b0, in_ready}, 32'd0);
    send_cfg(6'd0, 4'd2, 1'b0);
    check("ill_len0_err", {31'b0, err}, 32'd1);
    check("ill_len0_in_ready", {31'b0, in_ready}, 32'd0);
    cyc();
    check("ill_len0_err_drop", {31'b0, err}, 32'd0);
    send_cfg(6'd4, 4'd0, 1'b0);
    check("ill_num0_err", {31'b0, err}, 32'd1);
    check("ill_num0_in_ready", {31'b0, in_ready}, 32'd0);
    check("ill_num0_fv", {31'b0, frame_valid}, 32'd0);
    cyc();
    check("ill_num0_err_drop", {31'b0, err}, 32'd0);
    check("ill_keep_total", {26'b0, total_length}, 32'd21);

    // Backpressure on a full 32-element frame
    send_cfg(6'd8, 4'd4, 1'b0);
    for (int b = 0; b < 8; b++) send_beat(8'(100 + 4 * b));
    check("bp_fv", {31'b0, frame_valid}, 32'd1);
    cfg_valid = 1'b1;
    cfg_len   = 6'd2;
    cfg_num   = 4'd8;
    cfg_sign  = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check("bp_cfg_ready", {31'b0, cfg_ready}, 32'd0);
      cyc();
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_fv_hold", {31'b0, frame_valid}, 32'd1);
      check("bp_x0", {24'b0, x[0]}, 32'd100);
      check("bp_x31", {24'b0, x[31]}, 32'd131);
      check("bp_total", {26'b0, total_length}, 32'd32);
      check("bp_group", {28'b0, total_group}, 32'd4);
    end

    // Back-to-back: release and new config in the same cycle
    frame_ready = 1'b1;
    #1;
    check("b2b_cfg_ready_comb", {31'b0, cfg_ready}, 32'd1);
    cyc();
    frame_ready = 1'b0;
    cfg_valid   = 1'b0;
    check("b2b_in_ready", {31'b0, in_ready}, 32'd1);
    check("b2b_fv", {31'b0, frame_valid}, 32'd0);
    check("b2b_total", {26'b0, total_length}, 32'd16);
    check("b2b_group", {28'b0, total_group}, 32'd8);
    for (int b = 0; b < 4; b++) send_beat(8'(200 + 4 * b));
    check("b2b_fv_full", {31'b0, frame_valid}, 32'd1);
    for (int i = 0; i < 32; i++)
      check($sformatf("b2b_x%0d", i), {24'b0, x[i]}, (i < 16) ? 32'(200 + i) : 32'd0);
    release_frame();

    // Reset in the middle of a fill
    send_cfg(6'd8, 4'd4, 1'b1);
    for (int b = 0; b < 3; b++) send_beat(8'(4 * b + 50));
    check("mr_x0_pre", {24'b0, x[0]}, 32'd50);
    check("mr_x31_pre", {24'b0, x[31]}, 32'h80);
    rst = 1'b1;
    #1;
    check("mr_in_ready", {31'b0, in_ready}, 32'd0);
    check("mr_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    check("mr_fv", {31'b0, frame_valid}, 32'd0);
    check("mr_x0", {24'b0, x[0]}, 32'd0);
    check("mr_x31", {24'b0, x[31]}, 32'd0);
    check("mr_total", {26'b0, total_length}, 32'd0);
    check("mr_sign", {31'b0, sign_ctrl}, 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    send_cfg(6'd1, 4'd1, 1'b0);
    check("mr_new_in_ready", {31'b0, in_ready}, 32'd1);
    send_beat(8'd7);
    check("mr_new_fv", {31'b0, frame_valid}, 32'd1);
    check("mr_new_x0", {24'b0, x[0]}, 32'd7);
    check("mr_new_x1", {24'b0, x[1]}, 32'd0);
    check("mr_new_total", {26'b0, total_length}, 32'd1);
    release_frame();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sorter_frame_loader.md
# sorter_frame_loader

Upstream stage of `sorter_top`. It accepts a grouping configuration followed by a stream of fixed-width beats, and assembles the beats into one `MAX_DATALENGTH`-element frame. Unused slots are padded. The frame is then presented with `total_length`/`total_group`/`sign_ctrl` under a valid/ready handshake, so that the sorter always sees a complete, stable frame.

## Interface
- `DATAWIDTH`, default 8: element width in bits.
- `MAX_DATALENGTH`, default 32: number of slots in a frame.
- `BEAT_ELEMS`, default 4: elements per input beat. Must divide `MAX_DATALENGTH`.
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset. Asynchronous, active-high.
- `cfg_valid_i`, in, 1: configuration offered.
- `cfg_ready_o`, out, 1: configuration accepted this cycle.
- `cfg_group_len_i`, in, 6: elements per group. Legal range 1..32.
- `cfg_group_num_i`, in, 4: number of groups. Legal range 1..8.
- `cfg_sign_i`, in, 1: 1 = signed two's-complement elements.
- `in_valid_i`, in, 1: beat offered.
- `in_ready_o`, out, 1: beat accepted this cycle.
- `in_data_i[BEAT_ELEMS]`, in, `DATAWIDTH` each: element j of the beat.
- `frame_valid_o`, out, 1: frame available.
- `frame_ready_i`, in, 1: downstream consumes the frame.
- `x_o[MAX_DATALENGTH]`, out, `DATAWIDTH` each: assembled frame. Connects to the sorter's `x_i`.
- `total_length_o`, out, 6: group_len × group_num.
- `total_group_o`, out, 4: number of groups.
- `sign_ctrl_o`, out, 1: captured `cfg_sign_i`.
- `err_o`, out, 1: one-cycle pulse when an illegal configuration is rejected.

## Operation
- **FSM states:** IDLE, FILL, FULL.
- **IDLE:**
  - `cfg_ready_o`=1.
  - On `cfg_valid_i`, compute total = group_len × group_num using a 10-bit product.
  - Illegal configuration (len=0, num=0, or total>32): the configuration is consumed, `err_o` pulses the next cycle, and the FSM stays in IDLE.
  - Legal configuration: register total, num and sign; fill every slot with the pad value; clear the write pointer `wp`; go to FILL.
- **Pad value:** 0 when sign=0, and 1 followed by zeros (8'h80 at width 8) when sign=1. It is the minimum representable value, so padding never reaches top-k. The pad function lives in the package.
- **FILL:**
  - `in_ready_o`=1.
  - Each accepted beat writes element j to slot `wp`+j, but only where `wp`+j < total. Elements past total in the final beat are discarded.
  - `wp` advances by `BEAT_ELEMS`.
  - When `wp`+`BEAT_ELEMS` >= total on an accepted beat, go to FULL.
  - Beats needed = ceil(total/`BEAT_ELEMS`).
- **FULL:**
  - `frame_valid_o`=1. `x_o` and all metadata outputs are held stable until the handshake.
  - On `frame_ready_i`, go to IDLE.
  - `cfg_ready_o` = `frame_ready_i` in FULL. If `cfg_valid_i` and `frame_ready_i` are both high in the same cycle, the frame is released and the new configuration is taken in that cycle: legal → FILL, illegal → IDLE with `err_o`.
- **Ordering:** the first element of the first beat lands in `x_o[0]`. Groups are contiguous: group g occupies slots g·len .. g·len+len-1.
- No beat is accepted outside FILL. No configuration is accepted in FILL.

## Timing
- **Reset values** (asynchronous, immediate):
  - state IDLE.
  - `x_o` all 0.
  - `total_length_o`=0, `total_group_o`=0, `sign_ctrl_o`=0.
  - `frame_valid_o`=0, `err_o`=0, `in_ready_o`=0, `cfg_ready_o`=1.
- **Reset mid-FILL or mid-FULL:** the partial or pending frame is discarded without any handshake.
- **Latency:**
  - Config handshake at edge N → `in_ready_o`=1 from cycle N+1.
  - Last beat accepted at edge M → `frame_valid_o`=1 from cycle M+1.
  - Minimum frame period = 1 + beats + 1 cycles. With the back-to-back config path it is beats + 1.
- All outputs are registered except `cfg_ready_o` in FULL, which combinationally follows `frame_ready_i`.
- `err_o` is registered: high for exactly the one cycle after the rejected handshake.

## Structure
- **`sorter_pkg` additions:**
  - `loader_state_e` (IDLE/FILL/FULL).
  - `loader_cfg_t` struct {len, num, total, sign}.
  - Function `pad_value(sign)`.
  - Constant `LOADER_BEAT_ELEMS`=4.
- The single module is flat; no sub-module. The slot write is a generate loop of per-slot enables derived from `wp` and total.

## Test plan
- **Single group:** cfg len=20, num=1, sign=0; 5 beats carrying values 1..20 → frame_valid after the 5th beat; `x_o[0..19]`=1..20, `x_o[20..31]`=0; total_length_o=20, total_group_o=1.
- **Partial last beat, signed:** cfg len=7, num=3, sign=1; 6 beats with values 1..24 → `x_o[0..20]`=1..21; values 22..24 discarded; `x_o[21..31]`=8'h80; total_length_o=21.
- **Illegal configurations:** each of (len=9, num=4) → total 36; (len=0, num=2); (len=4, num=0) → `err_o` high for one cycle, in_ready never asserted, state stays IDLE.
- **Backpressure:** full frame of 32 elements; hold frame_ready_i=0 for 10 cycles → `x_o` and metadata unchanged and in_ready_o=0 throughout; a new cfg is not accepted until frame_ready_i=1.
- **Back-to-back:** in FULL, assert frame_ready_i and a new cfg (len=2, num=8) in the same cycle → FILL on the next cycle; 4 beats → second frame with total_length_o=16, total_group_o=8.
- **Reset mid-FILL:** assert rst_i after 3 of 8 beats → outputs return to reset values immediately; a new cfg is accepted cleanly afterwards.
